tea_io_uart: RTL
================

// Module: tea_io_uart
// PURPOSE
//  UART peripheral on the tea_cpu IO bus. It is the downstream consumer of io_addr/io_rd/io_wr/io_wrdata
//  and supplies io_rddata back to the core. It holds 8N1 TX/RX engines, one FIFO per direction and a
//  programmable 16-bit baud divisor, so firmware can talk to a host without cycle-counting loops.
// PARAMETERS
//  BASE_ADDR   5'h10   IO window base; the block decodes io_addr[4:3]==BASE_ADDR[4:3] (8-register window)
//  FIFO_DEPTH  4       entries per FIFO; power of 2, range 2..16
//  DIV_RESET   16'd433 reset value of the divisor; bit period = DIV+1 clocks
// PORTS
//  clk        in   1  system clock
//  rst        in   1  asynchronous reset, active-high
//  io_addr    in   5  IO register address
//  io_rd      in   1  read strobe; level, held >=2 cycles per access
//  io_wr      in   1  write strobe; level, held >=2 cycles per access
//  io_wrdata  in   8  write data; valid while io_wr is high
//  io_rddata  out  8  read data, combinational; 8'h00 when not selected (OR-able bus)
//  uart_rx    in   1  serial input, asynchronous to clk
//  uart_tx    out  1  serial output; idle high
//  irq        out  1  interrupt (only with TEA_UART_IRQ_EN; tied 0 otherwise)
// BEHAVIOUR
//  Reset values: uart_tx=1; irq=0; both FIFOs empty; all flags=0; div=DIV_RESET; both FSMs in IDLE.
//  Register map (offset = io_addr[2:0]):
//   0 DATA    W: push TX FIFO.  R: head of RX FIFO, popped after the access.
//   1 STATUS  R: {3'b0, frm_err, rx_ovf, tx_full, tx_empty, rx_avail}.  W: ignored.
//   2 CTRL    W: bit0=1 clears rx_ovf; bit1=1 clears frm_err; bits[3:2]=irq_en (IRQ build).
//             R: {4'b0, irq_en, 2'b0}.
//   3 DIV_LO  R/W: divisor[7:0].
//   4 DIV_HI  R/W: divisor[15:8].
//   5-7       R: 0.  W: ignored.
//  Access rules:
//   - Write takes effect on the rising edge of io_wr; exactly once per strobe.
//   - Read data is stable for the whole io_rd strobe.
//   - The RX pop occurs in the cycle after io_rd falls, so each strobe pops exactly once.
//   - Write to DATA while tx_full: byte dropped, no flag set.
//   - Read of DATA while RX empty: returns 0, no pop.
//  TX FSM: IDLE -> START -> DATA(x8, LSB first) -> STOP -> IDLE.
//   - Leaves IDLE on the first cycle the TX FIFO is non-empty; pops the FIFO on that cycle.
//   - Each bit lasts div+1 clocks.
//   - Back-to-back frames with no idle gap when the FIFO stays non-empty.
//  RX FSM:
//   - uart_rx passes a 2-flop synchroniser.
//   - IDLE: a falling edge starts a frame.
//   - START: re-checks low at (div+1)/2; if high, returns to IDLE (glitch rejected).
//   - DATA: samples 8 bits at mid-bit.
//   - STOP: mid-bit sample high -> push byte; if RX FIFO full, byte dropped and rx_ovf set.
//     Sample low -> frm_err set, byte discarded.
//  Divisor: bit counters reload from div at each bit boundary.
//   - A write mid-frame applies from the next bit.
//   - div=0 is legal (1 clock per bit).
//  FIFO: pointers wrap modulo FIFO_DEPTH; count is $clog2(FIFO_DEPTH)+1 bits.
//   - Simultaneous push and pop: both occur, count unchanged.
//   - Push to a full FIFO is ignored; pop from an empty FIFO is ignored.
//  Flags are sticky until cleared via CTRL.
//   - Set and clear in the same cycle: set wins.
//  Asserting rst mid-frame aborts both FSMs immediately; uart_tx returns high asynchronously.
// CONFIGURATION
//  TEA_UART_IRQ_EN defined:
//   - irq_en register present.
//   - irq is registered = (irq_en[0] & rx_avail) | (irq_en[1] & tx_empty), updated 1 cycle after the flag changes.
//  TEA_UART_IRQ_EN undefined:
//   - irq_en absent; CTRL bits[3:2] ignored and read 0; irq tied 1'b0.
// STRUCTURE
//  Package tea_uart_pkg:
//   - register offset localparams: OFS_DATA, OFS_STATUS, OFS_CTRL, OFS_DIV_LO, OFS_DIV_HI
//   - STATUS bit indices
//   - tx_state_t (IDLE, START, DATA, STOP)
//   - rx_state_t (IDLE, START, DATA, STOP)
//  Sub-module: tea_sync_fifo (WIDTH, DEPTH).
//   - Ports: push, pop, din, dout, full, empty.
//   - Instantiated twice: TX FIFO and RX FIFO.
// TESTING
//  1. DIV=3; write 8'hA5 to DATA -> uart_tx low 4 clk, then bits 1,0,1,0,0,1,0,1 (4 clk each), high 4 clk;
//     tx_empty=1 afterwards.
//  2. Write 5 bytes with FIFO_DEPTH=4 while the TX engine is idle -> the first byte starts sending and is
//     popped, so all 5 are accepted; 6th write while tx_full=1 is dropped.
//     Exactly 5 frames appear on uart_tx.
//  3. Drive frame 8'h3C on uart_rx at DIV=7 -> rx_avail=1; DATA read returns 8'h3C, then rx_avail=0.
//     Hold io_rd 2 cycles and confirm only one pop.
//  4. Send 5 frames with no reads -> rx_ovf=1 and the FIFO holds the first 4 bytes;
//     CTRL write 8'h01 -> rx_ovf=0.
//  5. Frame with stop bit low -> frm_err=1, no push.
//     2-clk low glitch on uart_rx at DIV=15 -> no frame started.
//  6. Assert rst mid-TX-frame -> uart_tx=1 in the same cycle, FIFOs empty, div=DIV_RESET.
//     IRQ build: irq_en=2'b01 with RX byte pending -> irq=1; irq=0 one cycle after it is popped.

Source files
------------

// File: rtl/tea_uart_pkg.sv
// Shared definitions for the tea_cpu IO-bus UART.
// Contents:
//   - register offsets within the 8-register IO window
//   - bit positions of the STATUS register
//   - TX and RX state encodings
//   - half_bit(): mid-bit sample offset used by the RX engine
package tea_uart_pkg;

    localparam logic [2:0] OFS_DATA   = 3'd0;
    localparam logic [2:0] OFS_STATUS = 3'd1;
    localparam logic [2:0] OFS_CTRL   = 3'd2;
    localparam logic [2:0] OFS_DIV_LO = 3'd3;
    localparam logic [2:0] OFS_DIV_HI = 3'd4;

    localparam int ST_RX_AVAIL = 0;
    localparam int ST_TX_EMPTY = 1;
    localparam int ST_TX_FULL  = 2;
    localparam int ST_RX_OVF   = 3;
    localparam int ST_FRM_ERR  = 4;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    // (div+1)/2 without needing a 17-bit intermediate.
    function automatic logic [15:0] half_bit(input logic [15:0] div);
        return {1'b0, div[15:1]} + {15'd0, div[0]};
    endfunction

endpackage

// File: rtl/tea_sync_fifo.sv
// Single-clock FIFO used for both the TX and RX byte queues.
// Ports:
//   clk, rst     clock and asynchronous active-high reset
//   push, din    write request and data; ignored while full
//   pop          read request; ignored while empty
//   dout         current head entry (combinational)
//   full, empty  occupancy flags
// DEPTH must be a power of two so the pointers wrap naturally.
module tea_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic             do_push_s;
    logic             do_pop_s;

    assign full      = (count_r == CW'(DEPTH));
    assign empty     = (count_r == {CW{1'b0}});
    assign do_push_s = push & ~full;
    assign do_pop_s  = pop & ~empty;
    assign dout      = mem_r[rd_ptr_r];

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Storage array; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

endmodule

// File: rtl/tea_io_uart.sv
// tea_io_uart: 8N1 UART peripheral on the tea_cpu IO bus.
// Ports:
//   clk, rst              system clock, asynchronous active-high reset
//   io_addr/io_rd/io_wr   IO bus address and level strobes (>=2 cycles each)
//   io_wrdata             write data, valid while io_wr is high
//   io_rddata             combinational read data, 8'h00 when not selected
//   uart_rx               asynchronous serial input
//   uart_tx               serial output, idle high, registered
//   irq                   interrupt output
// Optional feature: define TEA_UART_IRQ_EN to add the irq_en register and a
// registered interrupt; otherwise irq is tied low and CTRL[3:2] reads 0.
module tea_io_uart
    import tea_uart_pkg::*;
#(
    parameter logic [4:0]  BASE_ADDR  = 5'h10,
    parameter int          FIFO_DEPTH = 4,
    parameter logic [15:0] DIV_RESET  = 16'd433
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] io_addr,
    input  logic       io_rd,
    input  logic       io_wr,
    input  logic [7:0] io_wrdata,
    output logic [7:0] io_rddata,
    input  logic       uart_rx,
    output logic       uart_tx,
    output logic       irq
);

    // ---------------- bus decode ----------------
    logic       sel_s;
    logic [2:0] ofs_s;
    logic       wr_q_r;
    logic       wr_stb_s;
    logic       rd_data_r;
    logic       rx_pop_s;
    logic [15:0] div_r;

    assign sel_s    = (io_addr[4:3] == BASE_ADDR[4:3]);
    assign ofs_s    = io_addr[2:0];
    assign wr_stb_s = io_wr & ~wr_q_r & sel_s;
    // The RX head is popped only once the read strobe has dropped, so the
    // data seen by the core stays constant for the whole strobe.
    assign rx_pop_s = rd_data_r & ~io_rd;

    // Strobe history for write edge detection and deferred RX pop
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q_r    <= 1'b0;
            rd_data_r <= 1'b0;
        end else begin
            wr_q_r    <= io_wr;
            rd_data_r <= io_rd & sel_s & (ofs_s == OFS_DATA);
        end
    end

    // Baud divisor register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_r <= DIV_RESET;
        end else if (wr_stb_s && ofs_s == OFS_DIV_LO) begin
            div_r[7:0] <= io_wrdata;
        end else if (wr_stb_s && ofs_s == OFS_DIV_HI) begin
            div_r[15:8] <= io_wrdata;
        end else begin
            div_r <= div_r;
        end
    end

    // ---------------- FIFOs ----------------
    logic       tx_push_s;
    logic       tx_pop_s;
    logic       tx_full_s;
    logic       tx_empty_s;
    logic [7:0] tx_dout_s;
    logic       rx_push_s;
    logic       rx_full_s;
    logic       rx_empty_s;
    logic [7:0] rx_dout_s;
    logic [7:0] rx_shift_r;

    assign tx_push_s = wr_stb_s & (ofs_s == OFS_DATA);

    tea_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (tx_push_s),
        .pop   (tx_pop_s),
        .din   (io_wrdata),
        .dout  (tx_dout_s),
        .full  (tx_full_s),
        .empty (tx_empty_s)
    );

    tea_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rx_push_s),
        .pop   (rx_pop_s),
        .din   (rx_shift_r),
        .dout  (rx_dout_s),
        .full  (rx_full_s),
        .empty (rx_empty_s)
    );

    // ---------------- TX engine ----------------
    tx_state_t  tx_state_r;
    tx_state_t  tx_state_n;
    logic [15:0] tx_cnt_r;
    logic [15:0] tx_cnt_n;
    logic [2:0]  tx_idx_r;
    logic [2:0]  tx_idx_n;
    logic [7:0]  tx_shift_r;
    logic [7:0]  tx_shift_n;
    logic        tx_line_r;
    logic        tx_line_n;
    logic        tx_bit_end_s;

    assign tx_bit_end_s = (tx_cnt_r == 16'd0);
    assign uart_tx      = tx_line_r;

    // TX state register; the line is forced high asynchronously on reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state_r <= TX_IDLE;
            tx_cnt_r   <= 16'd0;
            tx_idx_r   <= 3'd0;
            tx_shift_r <= 8'd0;
            tx_line_r  <= 1'b1;
        end else begin
            tx_state_r <= tx_state_n;
            tx_cnt_r   <= tx_cnt_n;
            tx_idx_r   <= tx_idx_n;
            tx_shift_r <= tx_shift_n;
            tx_line_r  <= tx_line_n;
        end
    end

    // TX next-state and bit timing; a frame may start straight from STOP
    always_comb begin
        tx_state_n = tx_state_r;
        tx_cnt_n   = tx_cnt_r;
        tx_idx_n   = tx_idx_r;
        tx_shift_n = tx_shift_r;
        case (tx_state_r)
            TX_IDLE: begin
                if (!tx_empty_s) begin
                    tx_state_n = TX_START;
                    tx_cnt_n   = div_r;
                    tx_shift_n = tx_dout_s;
                end else begin
                    tx_state_n = TX_IDLE;
                end
            end
            TX_START: begin
                if (tx_bit_end_s) begin
                    tx_state_n = TX_DATA;
                    tx_cnt_n   = div_r;
                    tx_idx_n   = 3'd0;
                end else begin
                    tx_cnt_n = tx_cnt_r - 16'd1;
                end
            end
            TX_DATA: begin
                if (tx_bit_end_s) begin
                    tx_cnt_n = div_r;
                    if (tx_idx_r == 3'd7) begin
                        tx_state_n = TX_STOP;
                    end else begin
                        tx_idx_n   = tx_idx_r + 3'd1;
                        tx_shift_n = {1'b0, tx_shift_r[7:1]};
                    end
                end else begin
                    tx_cnt_n = tx_cnt_r - 16'd1;
                end
            end
            TX_STOP: begin
                if (tx_bit_end_s) begin
                    if (!tx_empty_s) begin
                        tx_state_n = TX_START;
                        tx_cnt_n   = div_r;
                        tx_shift_n = tx_dout_s;
                    end else begin
                        tx_state_n = TX_IDLE;
                    end
                end else begin
                    tx_cnt_n = tx_cnt_r - 16'd1;
                end
            end
            default: begin
                tx_state_n = TX_IDLE;
            end
        endcase
    end

    // TX outputs: FIFO pop on frame start and the next line level
    always_comb begin
        tx_pop_s = (tx_state_n == TX_START) && (tx_state_r != TX_START);
        case (tx_state_n)
            TX_START: tx_line_n = 1'b0;
            TX_DATA:  tx_line_n = tx_shift_n[0];
            default:  tx_line_n = 1'b1;
        endcase
    end

    // ---------------- RX engine ----------------
    logic        rx_meta_r;
    logic        rx_sync_r;
    logic        rx_prev_r;
    rx_state_t   rx_state_r;
    rx_state_t   rx_state_n;
    logic [15:0] rx_cnt_r;
    logic [15:0] rx_cnt_n;
    logic [2:0]  rx_idx_r;
    logic [2:0]  rx_idx_n;
    logic [7:0]  rx_shift_n;
    logic [15:0] rx_half_s;
    logic        rx_bit_end_s;
    logic        rx_stop_smp_s;
    logic        ovf_set_s;
    logic        ferr_set_s;

    assign rx_half_s    = half_bit(div_r);
    assign rx_bit_end_s = (rx_cnt_r == 16'd0);

    // Input synchroniser plus one more stage for falling-edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_r <= 1'b1;
            rx_sync_r <= 1'b1;
            rx_prev_r <= 1'b1;
        end else begin
            rx_meta_r <= uart_rx;
            rx_sync_r <= rx_meta_r;
            rx_prev_r <= rx_sync_r;
        end
    end

    // RX state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_state_r <= RX_IDLE;
            rx_cnt_r   <= 16'd0;
            rx_idx_r   <= 3'd0;
            rx_shift_r <= 8'd0;
        end else begin
            rx_state_r <= rx_state_n;
            rx_cnt_r   <= rx_cnt_n;
            rx_idx_r   <= rx_idx_n;
            rx_shift_r <= rx_shift_n;
        end
    end

    // RX next-state; with div=0 the edge cycle already is mid-bit, so the
    // start re-check is skipped and sampling begins with the next bit.
    always_comb begin
        rx_state_n = rx_state_r;
        rx_cnt_n   = rx_cnt_r;
        rx_idx_n   = rx_idx_r;
        rx_shift_n = rx_shift_r;
        case (rx_state_r)
            RX_IDLE: begin
                if (rx_prev_r && !rx_sync_r) begin
                    if (rx_half_s == 16'd0) begin
                        rx_state_n = RX_DATA;
                        rx_cnt_n   = div_r;
                        rx_idx_n   = 3'd0;
                    end else begin
                        rx_state_n = RX_START;
                        rx_cnt_n   = rx_half_s - 16'd1;
                    end
                end else begin
                    rx_state_n = RX_IDLE;
                end
            end
            RX_START: begin
                if (rx_bit_end_s) begin
                    if (rx_sync_r) begin
                        rx_state_n = RX_IDLE;
                    end else begin
                        rx_state_n = RX_DATA;
                        rx_cnt_n   = div_r;
                        rx_idx_n   = 3'd0;
                    end
                end else begin
                    rx_cnt_n = rx_cnt_r - 16'd1;
                end
            end
            RX_DATA: begin
                if (rx_bit_end_s) begin
                    rx_shift_n = {rx_sync_r, rx_shift_r[7:1]};
                    rx_cnt_n   = div_r;
                    if (rx_idx_r == 3'd7) begin
                        rx_state_n = RX_STOP;
                    end else begin
                        rx_idx_n = rx_idx_r + 3'd1;
                    end
                end else begin
                    rx_cnt_n = rx_cnt_r - 16'd1;
                end
            end
            RX_STOP: begin
                if (rx_bit_end_s) begin
                    rx_state_n = RX_IDLE;
                end else begin
                    rx_cnt_n = rx_cnt_r - 16'd1;
                end
            end
            default: begin
                rx_state_n = RX_IDLE;
            end
        endcase
    end

    // RX outputs: stop-bit verdict drives the push and the error flags
    always_comb begin
        rx_stop_smp_s = (rx_state_r == RX_STOP) && rx_bit_end_s;
        rx_push_s     = rx_stop_smp_s & rx_sync_r;
        ovf_set_s     = rx_push_s & rx_full_s;
        ferr_set_s    = rx_stop_smp_s & ~rx_sync_r;
    end

    // ---------------- flags ----------------
    logic rx_ovf_r;
    logic frm_err_r;
    logic clr_ovf_s;
    logic clr_ferr_s;

    assign clr_ovf_s  = wr_stb_s & (ofs_s == OFS_CTRL) & io_wrdata[0];
    assign clr_ferr_s = wr_stb_s & (ofs_s == OFS_CTRL) & io_wrdata[1];

    // Sticky error flags; a set in the same cycle as a clear wins
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_ovf_r  <= 1'b0;
            frm_err_r <= 1'b0;
        end else begin
            rx_ovf_r  <= ovf_set_s | (rx_ovf_r & ~clr_ovf_s);
            frm_err_r <= ferr_set_s | (frm_err_r & ~clr_ferr_s);
        end
    end

    // ---------------- interrupt ----------------
    logic [1:0] irq_en_rd_s;

`ifdef TEA_UART_IRQ_EN
    logic [1:0] irq_en_r;
    logic       irq_r;

    // Interrupt enable register and registered interrupt output
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq_en_r <= 2'b00;
            irq_r    <= 1'b0;
        end else begin
            if (wr_stb_s && ofs_s == OFS_CTRL) begin
                irq_en_r <= io_wrdata[3:2];
            end else begin
                irq_en_r <= irq_en_r;
            end
            irq_r <= (irq_en_r[0] & ~rx_empty_s) | (irq_en_r[1] & tx_empty_s);
        end
    end

    assign irq_en_rd_s = irq_en_r;
    assign irq         = irq_r;
`else
    assign irq_en_rd_s = 2'b00;
    assign irq         = 1'b0;
`endif

    // ---------------- read mux ----------------
    logic [7:0] status_s;
    logic [7:0] rd_word_s;

    // STATUS word assembly and register read multiplexer
    always_comb begin
        status_s              = 8'h00;
        status_s[ST_RX_AVAIL] = ~rx_empty_s;
        status_s[ST_TX_EMPTY] = tx_empty_s;
        status_s[ST_TX_FULL]  = tx_full_s;
        status_s[ST_RX_OVF]   = rx_ovf_r;
        status_s[ST_FRM_ERR]  = frm_err_r;
        if (io_rd && sel_s) begin
            case (ofs_s)
                OFS_DATA:   rd_word_s = rx_empty_s ? 8'h00 : rx_dout_s;
                OFS_STATUS: rd_word_s = status_s;
                OFS_CTRL:   rd_word_s = {4'b0000, irq_en_rd_s, 2'b00};
                OFS_DIV_LO: rd_word_s = div_r[7:0];
                OFS_DIV_HI: rd_word_s = div_r[15:8];
                default:    rd_word_s = 8'h00;
            endcase
        end else begin
            rd_word_s = 8'h00;
        end
    end

    assign io_rddata = rd_word_s;

endmodule
